usb_tx_phy: RTL and testbench

- Full-speed USB transmit PHY; the transmit counterpart of the USB receive PHY in the USB host datapath.
- Accepts bytes over a UTMI-style valid/ready handshake from the packet layer.
- Generates SYNC, LSB-first data with bit stuffing and NRZI encoding, then EOP.
- Drives the D+/D- pins and the output enable for the bidirectional pad.

---
 rtl/usb_tx_phy.sv | 206 ++++++++++++++++++++
 tb/tb_usb_tx_phy.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_phy.sv
// usb_tx_phy: full-speed USB transmit PHY.
//
// Takes bytes from the packet layer over a valid/ready handshake and serialises
// them onto D+/D- as SYNC, then LSB-first data with bit stuffing and NRZI
// encoding, then EOP (two bit times of SE0 followed by one bit time of J).
//
// Ports:
//   clkout2      system clock, all logic on the rising edge
//   reset        asynchronous reset, active low
//   io_txValid   packet layer has a byte on io_data (held for the whole packet)
//   io_data      byte to send, stable until io_txReady
//   io_txReady   one-cycle pulse, io_data is captured on this edge
//   io_txActive  high from the first SYNC cycle through the last EOP J cycle
//   io_txOe      pad output enable, equal to io_txActive
//   io_usbDp     D+ drive value
//   io_usbDn     D- drive value
//
// States:
//   state   | meaning
//   IDLE    | line parked at J, pad not driven, waiting for io_txValid
//   SYNC    | sending the 0000_0001 SYNC pattern
//   DATA    | sending a data byte, including any stuffed zero after its bits
//   EOP_SE0 | driving SE0 for two bit times
//   EOP_J   | driving J for one bit time before releasing the pad

module usb_tx_phy #(
    parameter int BIT_CLKS = 4
) (
    input  logic       clkout2,
    input  logic       reset,
    input  logic       io_txValid,
    input  logic [7:0] io_data,
    output logic       io_txReady,
    output logic       io_txActive,
    output logic       io_txOe,
    output logic       io_usbDp,
    output logic       io_usbDn
);

    localparam logic [3:0] BIT_LAST = 4'(BIT_CLKS - 1);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        EOP_SE0,
        EOP_J
    } txState_t;

    txState_t   state, stateNext;
    logic [3:0] bitCnt, bitCntNext;
    logic [2:0] bitIdx, bitIdxNext;
    logic [2:0] onesCnt, onesCntNext;
    logic [7:0] shiftReg, shiftRegNext;
    logic       curBit, curBitNext;     // logical bit currently on the line
    logic       stuffBit, stuffBitNext; // current slot is a stuffed zero
    logic       level, levelNext;       // NRZI line level, 1 = J, 0 = K
    logic       readyNext;

    logic       bitEnd;
    logic [2:0] onesAfter;
    logic [2:0] idxInc;
    logic       nextBit;
    logic       toEop;

    assign bitEnd    = (bitCnt == BIT_LAST);
    assign onesAfter = curBit ? (onesCnt + 3'd1) : 3'd0;
    assign idxInc    = bitIdx + 3'd1;

    always_ff @(posedge clkout2 or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            bitCnt   <= '0;
            bitIdx   <= '0;
            onesCnt  <= '0;
            shiftReg <= '0;
            curBit   <= 1'b0;
            stuffBit <= 1'b0;
            level    <= 1'b1;
        end else begin
            state    <= stateNext;
            bitCnt   <= bitCntNext;
            bitIdx   <= bitIdxNext;
            onesCnt  <= onesCntNext;
            shiftReg <= shiftRegNext;
            curBit   <= curBitNext;
            stuffBit <= stuffBitNext;
            level    <= levelNext;
        end
    end

    always_comb begin
        stateNext    = state;
        bitCntNext   = (state == IDLE || bitEnd) ? 4'd0 : (bitCnt + 4'd1);
        bitIdxNext   = bitIdx;
        onesCntNext  = onesCnt;
        shiftRegNext = shiftReg;
        curBitNext   = curBit;
        stuffBitNext = stuffBit;
        levelNext    = level;
        readyNext    = 1'b0;
        nextBit      = 1'b0;
        toEop        = 1'b0;

        case (state)
            IDLE: begin
                if (io_txValid) begin
                    // First SYNC bit is a logical 0, so the line starts at K.
                    stateNext    = SYNC;
                    bitIdxNext   = 3'd0;
                    onesCntNext  = 3'd0;
                    curBitNext   = 1'b0;
                    stuffBitNext = 1'b0;
                    levelNext    = 1'b0;
                end
            end

            SYNC, DATA: begin
                if (bitEnd) begin
                    onesCntNext = onesAfter;
                    if (!stuffBit && onesAfter == 3'd6) begin
                        // Insert a stuffed zero; the data bit index stays put.
                        stuffBitNext = 1'b1;
                        curBitNext   = 1'b0;
                        levelNext    = ~level;
                        onesCntNext  = 3'd0;
                    end else begin
                        stuffBitNext = 1'b0;
                        if (bitIdx == 3'd7) begin
                            bitIdxNext = 3'd0;
                            if (io_txValid) begin
                                readyNext    = 1'b1;
                                shiftRegNext = io_data;
                                stateNext    = DATA;
                                nextBit      = io_data[0];
                            end else begin
                                stateNext = EOP_SE0;
                                toEop     = 1'b1;
                            end
                        end else begin
                            bitIdxNext = idxInc;
                            nextBit    = (state == SYNC) ? (idxInc == 3'd7)
                                                         : shiftReg[idxInc];
                        end
                        if (!toEop) begin
                            curBitNext = nextBit;
                            if (!nextBit) begin
                                levelNext = ~level;
                            end
                        end
                    end
                end
            end

            EOP_SE0: begin
                if (bitEnd) begin
                    if (bitIdx == 3'd1) begin
                        stateNext  = EOP_J;
                        bitIdxNext = 3'd0;
                    end else begin
                        bitIdxNext = idxInc;
                    end
                end
            end

            EOP_J: begin
                if (bitEnd) begin
                    stateNext    = IDLE;
                    bitIdxNext   = 3'd0;
                    onesCntNext  = 3'd0;
                    curBitNext   = 1'b0;
                    stuffBitNext = 1'b0;
                    levelNext    = 1'b1;
                end
            end

            default: begin
                stateNext = IDLE;
                levelNext = 1'b1;
            end
        endcase
    end

    always_comb begin
        io_txReady  = (state == SYNC || state == DATA) ? readyNext : 1'b0;
        io_txActive = (state != IDLE);
        io_txOe     = (state != IDLE);
        io_usbDp    = 1'b1;
        io_usbDn    = 1'b0;
        case (state)
            SYNC, DATA: begin
                io_usbDp = level;
                io_usbDn = ~level;
            end
            EOP_SE0: begin
                io_usbDp = 1'b0;
                io_usbDn = 1'b0;
            end
            default: begin
                io_usbDp = 1'b1;
                io_usbDn = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_usb_tx_phy.sv
// tb_usb_tx_phy: self-checking bench for usb_tx_phy.
// A reference model turns each packet into the expected per-cycle pin symbols
// and ready pulses; the monitor pops and compares them while io_txOe is high.

module tb_usb_tx_phy;

    localparam int BC = 4;

    logic       clkout2;
    logic       reset;
    logic       io_txValid;
    logic [7:0] io_data;
    logic       io_txReady;
    logic       io_txActive;
    logic       io_txOe;
    logic       io_usbDp;
    logic       io_usbDn;

    int testsRun;
    int testsFailed;

    logic [7:0] pkt [8];
    logic [1:0] expSym [$];
    bit         expRdy [$];

    usb_tx_phy #(.BIT_CLKS(BC)) dut (
        .clkout2     (clkout2),
        .reset       (reset),
        .io_txValid  (io_txValid),
        .io_data     (io_data),
        .io_txReady  (io_txReady),
        .io_txActive (io_txActive),
        .io_txOe     (io_txOe),
        .io_usbDp    (io_usbDp),
        .io_usbDn    (io_usbDn)
    );

    initial clkout2 = 1'b0;
    always #5 clkout2 = ~clkout2;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: NRZI level starts at J; each logical bit occupies BC cycles.
    logic modelLevel;
    int   modelOnes;

    task automatic emitBit(input bit b);
        if (!b) modelLevel = ~modelLevel;
        for (int c = 0; c < BC; c++) begin
            expSym.push_back({modelLevel, ~modelLevel});
            expRdy.push_back(1'b0);
        end
    endtask

    task automatic buildExpected(input int n);
        logic [7:0] byteV;
        expSym.delete();
        expRdy.delete();
        modelLevel = 1'b1;
        modelOnes  = 0;
        for (int seg = 0; seg <= n; seg++) begin
            byteV = (seg == 0) ? 8'h80 : pkt[seg-1];
            for (int b = 0; b < 8; b++) begin
                emitBit(byteV[b]);
                modelOnes = byteV[b] ? modelOnes + 1 : 0;
                if (modelOnes == 6) begin
                    emitBit(1'b0);
                    modelOnes = 0;
                end
            end
            if (seg < n) expRdy[expRdy.size()-1] = 1'b1;
        end
        for (int c = 0; c < 2*BC; c++) begin
            expSym.push_back(2'b00);
            expRdy.push_back(1'b0);
        end
        for (int c = 0; c < BC; c++) begin
            expSym.push_back(2'b10);
            expRdy.push_back(1'b0);
        end
    endtask

    // Sends n bytes from pkt; valid drops dropDelay cycles after the last ready.
    // expLen < 0 means take the packet length from the model.
    task automatic runPacket(input string tag, input int n, input int dropDelay, input int expLen);
        int  cyc, idx, sent, dropCnt, want;
        bit  seenOe, done, rdyNow;
        buildExpected(n);
        want = (expLen < 0) ? expSym.size() : expLen;
        @(posedge clkout2);
        #1;
        io_txValid = 1'b1;
        io_data    = pkt[0];
        sent = 0; dropCnt = -1; cyc = 0; idx = 0; seenOe = 0; done = 0;
        while (!done && cyc < 2000) begin
            @(negedge clkout2);
            if (io_txOe) begin
                if (!seenOe) checkVal({tag, "_latency"}, cyc, 1);
                seenOe = 1;
                if (expSym.size() > 0) begin
                    checkVal({tag, "_pins"}, {io_usbDp, io_usbDn}, expSym.pop_front());
                    checkVal({tag, "_ready"}, io_txReady, expRdy.pop_front());
                end else begin
                    checkVal({tag, "_overrun"}, idx, want);
                end
                checkVal({tag, "_active"}, io_txActive, 1);
                idx++;
            end else if (seenOe) begin
                done = 1;
            end
            rdyNow = io_txReady;
            @(posedge clkout2);
            #1;
            cyc++;
            if (rdyNow) begin
                sent++;
                if (sent < n) begin
                    io_data = pkt[sent];
                end else begin
                    io_data = 8'($urandom);
                    dropCnt = dropDelay;
                end
            end
            if (dropCnt == 0) io_txValid = 1'b0;
            if (dropCnt >= 0) dropCnt--;
        end
        if (!done) checkVal({tag, "_timeout"}, 0, 1);
        checkVal({tag, "_oeLen"}, idx, want);
        checkVal({tag, "_bytes"}, sent, n);
        checkVal({tag, "_idle"}, {io_usbDp, io_usbDn, io_txOe, io_txReady}, 4'b1000);
        io_txValid = 1'b0;
        repeat (3) @(posedge clkout2);
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        reset       = 1'b0;
        io_txValid  = 1'b0;
        io_data     = 8'h00;
        #12;
        checkVal("rst_vals", {io_txReady, io_txActive, io_txOe, io_usbDp, io_usbDn}, 5'b00010);
        @(negedge clkout2);
        reset = 1'b1;
        repeat (3) @(posedge clkout2);
        #1;
        checkVal("idle_after_rst", {io_txOe, io_usbDp, io_usbDn}, 3'b010);

        pkt[0] = 8'hA5;
        runPacket("t1_a5", 1, 0, 76);

        pkt[0] = 8'h3C; pkt[1] = 8'h3C; pkt[2] = 8'h3C;
        runPacket("t2_3c", 3, 0, 140);

        pkt[0] = 8'hFF;
        runPacket("t3_ff", 1, 0, 80);

        pkt[0] = 8'h00; pkt[1] = 8'hFE;
        runPacket("t4_00fe", 2, 0, 112);

        // Reset mid-DATA of a 4-byte packet.
        @(posedge clkout2);
        #1;
        io_txValid = 1'b1;
        io_data    = 8'h96;
        repeat (50) @(posedge clkout2);
        @(negedge clkout2);
        #2;
        checkVal("t5_busy", io_txOe, 1);
        reset = 1'b0;
        #1;
        checkVal("t5_rst_async", {io_txOe, io_txActive, io_usbDp, io_usbDn, io_txReady}, 5'b00100);
        io_txValid = 1'b0;
        repeat (2) @(posedge clkout2);
        @(negedge clkout2);
        #2;
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clkout2);
            checkVal("t5_stay_idle", {io_txOe, io_usbDp, io_usbDn}, 3'b010);
        end
        pkt[0] = 8'h5A;
        runPacket("t5_restart", 1, 0, 76);

        pkt[0] = 8'h11; pkt[1] = 8'h22; pkt[2] = 8'h33;
        runPacket("t6_drop", 2, 12, 108);

        for (int i = 0; i < 4; i++) pkt[i] = 8'($urandom);
        pkt[1] = 8'h7F;
        runPacket("t7_rand", 4, 0, -1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
